// File: rtl/table_cfg_ctrl.sv
// Table configuration controller: bulk clear of three config tables plus single host read/write access.
// Optional CLR_KEY_GATE_EN: hold Key_in_o low while a clear is running.
module table_cfg_ctrl #(
   parameter int unsigned RD_TIMEOUT = 16
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        clr_start,
   input  logic [3:0]  clr_data,
   output logic        clr_busy,
   output logic        clr_done,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [1:0]  host_sel,
   input  logic [11:0] host_addr,
   input  logic [3:0]  host_wdata,
   output logic        host_ack,
   output logic [3:0]  host_rdata,
   output logic        host_rvalid,
   output logic        host_err,
   input  logic        Key_in_i,
   output logic        Key_in_o,
   output logic        enb_1,
   output logic        web_1,
   output logic [11:0] addrb_1,
   output logic [3:0]  dib_1,
   input  logic [3:0]  dob_1,
   input  logic        dob_valid_1,
   output logic        enb_2,
   output logic        web_2,
   output logic [11:0] addrb_2,
   output logic [3:0]  dib_2,
   input  logic [3:0]  dob_2,
   input  logic        dob_valid_2,
   output logic        enb_3,
   output logic        web_3,
   output logic [11:0] addrb_3,
   output logic [3:0]  dib_3,
   input  logic [3:0]  dob_3,
   input  logic        dob_valid_3
);

   typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, RD_WAIT} state_t;

   localparam logic [15:0] WAIT_LAST = 16'(RD_TIMEOUT - 1);

   state_t      state;
   logic [11:0] cnt;
   logic [3:0]  clr_val;
   logic [1:0]  sel_q;
   logic        we_q;
   logic [15:0] wait_cnt;

   logic        clr_wr;
   logic [11:0] clr_addr_nxt;
   logic [3:0]  clr_data_nxt;
   logic        host_iss;
   logic        sel_valid;
   logic [3:0]  sel_data;

   // Port outputs are registered, so the clear write for the address the
   // next cycle will show is prepared one edge early.
   always_comb begin
      clr_wr       = 1'b0;
      clr_addr_nxt = '0;
      clr_data_nxt = clr_data;
      host_iss     = 1'b0;
      if (state == IDLE) begin
         clr_wr   = clr_start;
         host_iss = !clr_start && host_req;
      end else if (state == CLEAR) begin
         clr_wr       = (cnt != 12'hFFF);
         clr_addr_nxt = cnt + 12'd1;
         clr_data_nxt = clr_val;
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      case (sel_q)
         2'd1: begin sel_valid = dob_valid_1; sel_data = dob_1; end
         2'd2: begin sel_valid = dob_valid_2; sel_data = dob_2; end
         2'd3: begin sel_valid = dob_valid_3; sel_data = dob_3; end
         default: begin sel_valid = 1'b0; sel_data = '0; end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         clr_val     <= '0;
         sel_q       <= '0;
         we_q        <= 1'b0;
         wait_cnt    <= '0;
         clr_busy    <= 1'b0;
         clr_done    <= 1'b0;
         host_ack    <= 1'b0;
         host_rdata  <= '0;
         host_rvalid <= 1'b0;
         host_err    <= 1'b0;
         enb_1 <= 1'b0; web_1 <= 1'b0; addrb_1 <= '0; dib_1 <= '0;
         enb_2 <= 1'b0; web_2 <= 1'b0; addrb_2 <= '0; dib_2 <= '0;
         enb_3 <= 1'b0; web_3 <= 1'b0; addrb_3 <= '0; dib_3 <= '0;
      end else begin
         clr_done    <= 1'b0;
         host_ack    <= 1'b0;
         host_rvalid <= 1'b0;
         host_err    <= 1'b0;
         enb_1 <= 1'b0; web_1 <= 1'b0; addrb_1 <= '0; dib_1 <= '0;
         enb_2 <= 1'b0; web_2 <= 1'b0; addrb_2 <= '0; dib_2 <= '0;
         enb_3 <= 1'b0; web_3 <= 1'b0; addrb_3 <= '0; dib_3 <= '0;

         case (state)
            IDLE: begin
               if (clr_start) begin
                  state    <= CLEAR;
                  cnt      <= '0;
                  clr_val  <= clr_data;
                  clr_busy <= 1'b1;
               end else if (host_req) begin
                  state    <= ISSUE;
                  sel_q    <= host_sel;
                  we_q     <= host_we;
                  host_ack <= 1'b1;
                  host_err <= (host_sel == 2'd0);
               end
            end
            CLEAR: begin
               if (cnt == 12'hFFF) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  clr_busy <= 1'b0;
                  clr_done <= 1'b1;
               end else begin
                  cnt <= cnt + 12'd1;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= (sel_q != 2'd0 && !we_q) ? RD_WAIT : IDLE;
            end
            RD_WAIT: begin
               if (sel_valid) begin
                  host_rvalid <= 1'b1;
                  host_rdata  <= sel_data;
                  state       <= IDLE;
               end else if (wait_cnt == WAIT_LAST) begin
                  host_rvalid <= 1'b1;
                  host_err    <= 1'b1;
                  host_rdata  <= '0;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase

         // Tables 2 and 3 are shallower; their ports stay idle past their depth.
         if (clr_wr) begin
            enb_1 <= 1'b1; web_1 <= 1'b1; addrb_1 <= clr_addr_nxt; dib_1 <= clr_data_nxt;
            if (clr_addr_nxt < 12'd2048) begin
               enb_2 <= 1'b1; web_2 <= 1'b1; addrb_2 <= clr_addr_nxt; dib_2 <= clr_data_nxt;
            end
            if (clr_addr_nxt < 12'd1024) begin
               enb_3 <= 1'b1; web_3 <= 1'b1; addrb_3 <= clr_addr_nxt; dib_3 <= clr_data_nxt;
            end
         end

         if (host_iss) begin
            case (host_sel)
               2'd1: begin enb_1 <= 1'b1; web_1 <= host_we; addrb_1 <= host_addr; dib_1 <= host_wdata; end
               2'd2: begin enb_2 <= 1'b1; web_2 <= host_we; addrb_2 <= host_addr; dib_2 <= host_wdata; end
               2'd3: begin enb_3 <= 1'b1; web_3 <= host_we; addrb_3 <= host_addr; dib_3 <= host_wdata; end
               default: ;
            endcase
         end
      end
   end

`ifdef CLR_KEY_GATE_EN
   assign Key_in_o = Key_in_i & ~clr_busy;
`else
   assign Key_in_o = Key_in_i;
`endif

endmodule

// File: doc/table_cfg_ctrl.md
TABLE_CFG_CTRL -- requirements
Module: table_cfg_ctrl

Interface
REQ-001 Parameter RD_TIMEOUT, default 16, SHALL be the maximum number of cycles waited for dob_valid_n after a host read.
REQ-002 sys_clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 clr_start  input  1  one-cycle request to fill all three tables.
REQ-005 clr_data  input  4  fill value, captured when clr_start is accepted.
REQ-006 clr_busy  output  1  high while the clear sequence runs.
REQ-007 clr_done  output  1  one-cycle pulse at clear completion.
REQ-008 host_req  input  1  host access request, held until host_ack.
REQ-009 host_we  input  1  0 = read, 1 = write.
REQ-010 host_sel  input  2  target table 1..3; 0 is illegal.
REQ-011 host_addr  input  12  table address.
REQ-012 host_wdata  input  4  write data.
REQ-013 host_ack  output  1  one-cycle accept pulse.
REQ-014 host_rdata  output  4  read result.
REQ-015 host_rvalid  output  1  one-cycle read-result strobe.
REQ-016 host_err  output  1  one-cycle pulse on illegal host_sel or read timeout.
REQ-017 Key_in_i  input  1  key-valid from the key source.
REQ-018 Key_in_o  output  1  key-valid to the sketch datapath.
REQ-019 enb_n, web_n (n=1..3)  output  1 each  table config enable / write type (1 = write).
REQ-020 addrb_n  output  12; dib_n  output  4  table config address / write data.
REQ-021 dob_n  input  4; dob_valid_n  input  1  table read data / valid.

Function
REQ-022 The FSM SHALL have states IDLE, CLEAR, ISSUE, RD_WAIT.
REQ-023 In IDLE, clr_start SHALL go to CLEAR with cnt=0 and latch clr_data; otherwise host_req SHALL go to ISSUE; if both are high, CLEAR SHALL win and host_req stays pending.
REQ-024 In CLEAR, each cycle SHALL write latched data at address cnt: enb_1=web_1=1 always; enb_2=web_2=1 only while cnt<2048; enb_3=web_3=1 only while cnt<1024.
REQ-025 cnt is 12-bit, +1 per cycle; after the write at cnt=4095 the FSM SHALL go to IDLE (4096 write cycles total); clr_busy SHALL fall and clr_done SHALL pulse in the first IDLE cycle.
REQ-026 clr_start outside IDLE SHALL be ignored (not queued).
REQ-027 ISSUE SHALL last one cycle with host_ack=1; for host_sel 1..3: enb_sel=1, web_sel=host_we, addrb_sel=host_addr, dib_sel=host_wdata; a write SHALL return to IDLE, a read SHALL go to RD_WAIT.
REQ-028 host_sel=0 SHALL pulse host_ack and host_err together, assert no enb_n, and return to IDLE.
REQ-029 host_addr bits above the table width (bit 11 for table 2, bits 11:10 for table 3) SHALL be forwarded unchanged.
REQ-030 In RD_WAIT, the first cycle with dob_valid_sel=1 SHALL produce host_rdata=dob_sel with host_rvalid=1 on the next cycle, then IDLE; dob_valid of unselected tables SHALL be ignored.
REQ-031 With no dob_valid_sel for RD_TIMEOUT cycles, the block SHALL pulse host_rvalid and host_err, drive host_rdata=0, and return to IDLE.
REQ-032 host_req sampled high in IDLE at edge k SHALL produce host_ack and enb_sel in cycle k+1; the host drops host_req after host_ack; back-to-back writes SHALL sustain one access per 2 cycles.
REQ-033 All outputs except Key_in_o SHALL be registered; undriven enb_n/web_n/addrb_n/dib_n SHALL be 0.

Reset
REQ-034 rst_n low at a clock edge SHALL force IDLE, cnt=0, latched data=0, and all registered outputs 0 from the next cycle.
REQ-035 Reset during CLEAR SHALL abandon the clear without clr_done; reset during RD_WAIT SHALL suppress host_rvalid and host_err.

Configuration
REQ-036 With CLR_KEY_GATE_EN defined, Key_in_o SHALL equal Key_in_i AND NOT clr_busy (combinational, zero latency).
REQ-037 Without CLR_KEY_GATE_EN, Key_in_o SHALL equal Key_in_i unconditionally; clr_busy is still generated.

Verification
REQ-038 clr_start, clr_data=4'hA -> 4096 writes to table 1, 2048 to table 2, 1024 to table 3, all data 4'hA; clr_done pulses once, 4097 cycles after start.
REQ-039 clr_start and host_req (write, sel=2) in the same cycle -> clear runs first; host_ack only after clr_done; then addrb_2=host_addr, dib_2=host_wdata.
REQ-040 Read sel=3, addr 12'h3FF, dob_valid_3 asserted 3 cycles after enb_3 with dob_3=4'h5 -> host_rvalid with host_rdata=4'h5; a dob_valid_1 pulse during the wait is ignored.
REQ-041 Read sel=1 with dob_valid_1 never asserted -> after 16 cycles, host_rvalid=host_err=1 and host_rdata=0; host_sel=0 -> ack+err, no enb_n.
REQ-042 rst_n low at cnt=100 -> all outputs 0 next cycle, no clr_done; Key_in_i=1 during clear -> Key_in_o=0 with the macro defined, 1 without.
